// File: rtl/tank_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tank_fill_ctrl
//
// Closed-loop level controller that sits in front of the tank level counter.
// It takes a target level and issues single-cycle fill or consume pulses to the
// counter until the reported height matches the target, then reports done.
// It faults on a tank overflow/underflow error or when the per-operation pulse
// budget runs out.
//
// Each step is EVAL (1 cycle) -> PULSE (1 cycle) -> WAIT (GAP cycles). The WAIT
// phase gives the counter time to update height before it is compared again.
//
// Optional feature macro: TANK_AUTO_REFILL_EN
//   defined   : in DONE, if height + HYST < target (no wrap), a new fill
//               operation starts automatically.
//   undefined : DONE holds regardless of height drift.
//
// Parameters:
//   WIDTH      width of target, height and pulse_cnt
//   GAP        idle cycles after each pulse before height is re-compared (>= 1)
//   MAX_PULSES pulse budget per operation before timeout fault
//   HYST       refill hysteresis band (auto-refill builds only)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request new operation; accepted only in IDLE or DONE
//   target     desired level, latched on an accepted start
//   height     current level from the tank counter
//   tank_error overflow/underflow flag from the tank counter
//   abort      cancel the current operation (ignored in FAULT)
//   fill       one-cycle fill pulse to the tank
//   consume    one-cycle consume pulse to the tank
//   busy       high in EVAL/PULSE/WAIT
//   done       high while in DONE
//   fault      high while in FAULT
//   fault_code 01 tank error, 10 timeout, 00 none
//   pulse_cnt  pulses issued in the current operation (saturating)
// -----------------------------------------------------------------------------
module tank_fill_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAP        = 2,
    parameter int MAX_PULSES = 255,
    parameter int HYST       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] height,
    input  logic             tank_error,
    input  logic             abort,
    output logic             fill,
    output logic             consume,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [WIDTH-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_PULSE,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TANK    = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam int               GAP_W   = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_PULSES);

`ifdef TANK_AUTO_REFILL_EN
    localparam bit AUTO_REFILL = 1'b1;
`else
    localparam bit AUTO_REFILL = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               dir_fill_q, dir_fill_d;   // 1: fill, 0: consume
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         fc_q, fc_d;

    // Refill threshold, one bit wider so height + HYST cannot wrap.
    logic [WIDTH:0]     refill_sum;
    logic               refill_req;

    assign refill_sum = {1'b0, height} + (WIDTH + 1)'(HYST);
    assign refill_req = AUTO_REFILL && (refill_sum < {1'b0, target_q});

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        dir_fill_d = dir_fill_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        fc_d       = fc_q;

        if (abort && (state_q != S_FAULT)) begin
            state_d = S_IDLE;
            gap_d   = '0;
        end else if (tank_error && (state_q inside {S_EVAL, S_PULSE, S_WAIT, S_DONE})) begin
            state_d = S_FAULT;
            fc_d    = FC_TANK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        target_d = target;
                        cnt_d    = '0;
                        fc_d     = FC_NONE;
                        state_d  = S_EVAL;
                    end
                end

                S_EVAL: begin
                    if (height == target_q) begin
                        state_d = S_DONE;
                    end else if (cnt_q == MAX_CNT) begin
                        state_d = S_FAULT;
                        fc_d    = FC_TIMEOUT;
                    end else begin
                        // Direction is chosen afresh each step, so an external
                        // disturbance simply reverses it.
                        dir_fill_d = (height < target_q);
                        state_d    = S_PULSE;
                    end
                end

                S_PULSE: begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    gap_d   = GAP_LD;
                    state_d = S_WAIT;
                end

                S_WAIT: begin
                    // The counter is loaded with GAP, so WAIT lasts GAP cycles.
                    if (gap_q <= GAP_W'(1)) begin
                        gap_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end

                S_DONE: begin
                    if (start) begin
                        target_d = target;
                        cnt_d    = '0;
                        fc_d     = FC_NONE;
                        state_d  = S_EVAL;
                    end else if (refill_req) begin
                        cnt_d   = '0;
                        state_d = S_EVAL;
                    end
                end

                S_FAULT: begin
                    // Held until reset.
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dir_fill_q <= 1'b0;
            target_q   <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            fc_q       <= FC_NONE;
        end else begin
            state_q    <= state_d;
            dir_fill_q <= dir_fill_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            fc_q       <= fc_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output
    // combinationally.
    assign fill       = (state_q == S_PULSE) &&  dir_fill_q;
    assign consume    = (state_q == S_PULSE) && !dir_fill_q;
    assign busy       = (state_q inside {S_EVAL, S_PULSE, S_WAIT});
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fc_q;
    assign pulse_cnt  = cnt_q;

endmodule

// File: tb/tb_tank_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tank_fill_ctrl
//
// Self-checking bench for tank_fill_ctrl. A small tank model integrates the
// fill/consume pulses into height. Cycle numbering for an operation: the edge
// that samples start is cycle 1; outputs are sampled on the falling edge after
// each rising edge. One extra instance with MAX_PULSES=2 exercises the timeout.
// -----------------------------------------------------------------------------
module tb_tank_fill_ctrl;

    localparam int W    = 8;
    localparam int GAP  = 2;
    localparam int STEP = 2 + GAP;
    localparam int HYST = 4;
    localparam int BUDGET = 2 + 256 * STEP + 8;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    // Main instance
    logic         start, tank_error, abort;
    logic [W-1:0] target, height;
    logic         fill, consume, busy, done, fault;
    logic [1:0]   fault_code;
    logic [W-1:0] pulse_cnt;

    // Timeout instance
    logic         mp_start, mp_tank_error, mp_abort;
    logic [W-1:0] mp_target, mp_height;
    logic         mp_fill, mp_consume, mp_busy, mp_done, mp_fault;
    logic [1:0]   mp_fault_code;
    logic [W-1:0] mp_pulse_cnt;

    // Height override for the main tank model
    logic         ovr_en;
    logic [W-1:0] ovr_val;

    int n_checks = 0;
    int n_fail   = 0;

    tank_fill_ctrl #(.WIDTH(W), .GAP(GAP), .MAX_PULSES(255), .HYST(HYST)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .height(height),
        .tank_error(tank_error), .abort(abort), .fill(fill), .consume(consume),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
        .pulse_cnt(pulse_cnt)
    );

    tank_fill_ctrl #(.WIDTH(W), .GAP(GAP), .MAX_PULSES(2), .HYST(HYST)) dut_mp (
        .clk(clk), .rst(rst), .start(mp_start), .target(mp_target), .height(mp_height),
        .tank_error(mp_tank_error), .abort(mp_abort), .fill(mp_fill), .consume(mp_consume),
        .busy(mp_busy), .done(mp_done), .fault(mp_fault), .fault_code(mp_fault_code),
        .pulse_cnt(mp_pulse_cnt)
    );

    // Tank models: one unit per pulse, visible after the edge that ends the pulse.
    always @(posedge clk or posedge rst) begin
        if (rst)                                       height <= '0;
        else if (ovr_en)                               height <= ovr_val;
        else if (fill && !consume && height != 8'hFF)  height <= height + 8'd1;
        else if (consume && !fill && height != 8'h00)  height <= height - 8'd1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst)                                                  mp_height <= '0;
        else if (mp_fill && !mp_consume && mp_height != 8'hFF)    mp_height <= mp_height + 8'd1;
        else if (mp_consume && !mp_fill && mp_height != 8'h00)    mp_height <= mp_height - 8'd1;
    end

    typedef struct {
        logic [W-1:0] h0;
        logic [W-1:0] tgt;
        int           nf;
        int           nc;
        int           done_cyc;
        int           pc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one operation and compare it against the expected pulse counts,
    // completion cycle and final pulse count. prep aborts to IDLE and presets
    // the tank height first; without prep the operation starts from the
    // current state (e.g. DONE) and height.
    task automatic run_op(input bit prep, input logic [W-1:0] h0, input logic [W-1:0] tgt,
                          input int exp_nf, input int exp_nc, input int exp_done,
                          input int exp_pc, input string tag);
        int cyc, nf, nc, k, bad, both, nbusy;
        if (prep) begin
            abort = 1'b1; step(); abort = 1'b0;
            ovr_en = 1'b1; ovr_val = h0; step(); ovr_en = 1'b0;
        end
        start = 1'b1; target = tgt; step(); start = 1'b0;
        target = W'($urandom);   // must be ignored while busy
        cyc = 1; nf = 0; nc = 0; k = 0; bad = 0; both = 0; nbusy = 0;
        while (!done && cyc < BUDGET) begin
            step();
            cyc++;
            if (fill || consume) begin
                if (cyc != 2 + k * STEP) bad++;
                k++;
            end
            if (fill) nf++;
            if (consume) nc++;
            if (fill && consume) both++;
            if (!done && !busy) nbusy++;
        end
        check({tag, " done_cycle"}, cyc, exp_done);
        check({tag, " fills"}, nf, exp_nf);
        check({tag, " consumes"}, nc, exp_nc);
        check({tag, " pulse_cnt"}, pulse_cnt, exp_pc);
        check({tag, " height"}, height, tgt);
        check({tag, " misplaced_pulses"}, bad, 0);
        check({tag, " fill_and_consume"}, both, 0);
        check({tag, " busy_gaps"}, nbusy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, cyc, nf, dropped;
        int h0, tgt, d;
        int exp_done;

        vecs[0] = '{h0: 8'd0,   tgt: 8'd3,   nf: 3, nc: 0, done_cyc: 14, pc: 3};
        vecs[1] = '{h0: 8'd5,   tgt: 8'd2,   nf: 0, nc: 3, done_cyc: 14, pc: 3};
        vecs[2] = '{h0: 8'd7,   tgt: 8'd7,   nf: 0, nc: 0, done_cyc: 2,  pc: 0};
        vecs[3] = '{h0: 8'd254, tgt: 8'd255, nf: 1, nc: 0, done_cyc: 6,  pc: 1};
        vecs[4] = '{h0: 8'd1,   tgt: 8'd0,   nf: 0, nc: 1, done_cyc: 6,  pc: 1};
        vecs[5] = '{h0: 8'd100, tgt: 8'd108, nf: 8, nc: 0, done_cyc: 34, pc: 8};

        rst = 1'b1; start = 1'b0; abort = 1'b0; tank_error = 1'b0; target = '0;
        ovr_en = 1'b0; ovr_val = '0;
        mp_start = 1'b0; mp_abort = 1'b0; mp_tank_error = 1'b0; mp_target = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst fill", fill, 0);
        check("rst consume", consume, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst fault", fault, 0);
        check("rst fault_code", fault_code, 0);
        check("rst pulse_cnt", pulse_cnt, 0);
        check("rst mp_fault", mp_fault, 0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, vecs[i].h0, vecs[i].tgt, vecs[i].nf, vecs[i].nc,
                   vecs[i].done_cyc, vecs[i].pc, $sformatf("vec%0d", i));
        end

        // tank_error during WAIT -> FAULT 01; start and abort ignored
        abort = 1'b1; step(); abort = 1'b0;
        ovr_en = 1'b1; ovr_val = 8'd0; step(); ovr_en = 1'b0;
        start = 1'b1; target = 8'd10; step(); start = 1'b0;
        step();
        check("err first_fill", fill, 1);
        step();
        tank_error = 1'b1; step(); tank_error = 1'b0;
        check("err fault", fault, 1);
        check("err fault_code", fault_code, 2'b01);
        check("err busy", busy, 0);
        start = 1'b1; step(); start = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (fill || consume) cnt++;
            step();
        end
        check("err pulses_after", cnt, 0);
        check("err fault_held", fault, 1);
        check("err code_held", fault_code, 2'b01);
        rst = 1'b1; step(); rst = 1'b0; step();
        check("err cleared_by_rst", fault, 0);
        check("err code_cleared", fault_code, 0);

        // abort during WAIT of a 4-pulse fill
        ovr_en = 1'b1; ovr_val = 8'd0; step(); ovr_en = 1'b0;
        start = 1'b1; target = 8'd4; step(); start = 1'b0;
        cyc = 1; nf = 0;
        while (nf < 2 && cyc < 40) begin
            step(); cyc++;
            if (fill) nf++;
        end
        check("abort fill_cycle", cyc, 6);
        step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort fault", fault, 0);
        check("abort pulse", {30'd0, fill, consume}, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (fill || consume || busy) cnt++;
        end
        check("abort idle_activity", cnt, 0);
        run_op(1'b1, 8'd2, 8'd4, 2, 0, 10, 2, "after_abort");

        // Pulse budget exhaustion on the MAX_PULSES=2 instance
        mp_start = 1'b1; mp_target = 8'd5; step(); mp_start = 1'b0;
        cyc = 1; nf = 0;
        while (!mp_fault && cyc < 40) begin
            step(); cyc++;
            if (mp_fill) nf++;
        end
        check("timeout fault_cycle", cyc, 10);
        check("timeout fills", nf, 2);
        check("timeout fault_code", mp_fault_code, 2'b10);
        check("timeout pulse_cnt", mp_pulse_cnt, 2);
        check("timeout height", mp_height, 2);

        // DONE at height 10, then drift
        run_op(1'b1, 8'd0, 8'd10, 10, 0, 42, 10, "fill10");
        ovr_en = 1'b1; ovr_val = 8'd6; step(); ovr_en = 1'b0;
        cnt = 0; d = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fill || consume) cnt++;
            if (!done) d++;
        end
        check("hold6 pulses", cnt, 0);
        check("hold6 done_low", d, 0);
        ovr_en = 1'b1; ovr_val = 8'd5; step(); ovr_en = 1'b0;
`ifdef TANK_AUTO_REFILL_EN
        nf = 0; dropped = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (fill) nf++;
            if (!done) dropped = 1;
            else if (dropped != 0) break;
        end
        check("refill done_dropped", dropped, 1);
        check("refill done", done, 1);
        check("refill fills", nf, 5);
        check("refill height", height, 10);
        check("refill pulse_cnt", pulse_cnt, 5);
`else
        cnt = 0; d = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fill || consume) cnt++;
            if (!done) d++;
        end
        check("hold5 pulses", cnt, 0);
        check("hold5 done_low", d, 0);
        ovr_en = 1'b1; ovr_val = 8'd10; step(); ovr_en = 1'b0;
`endif

        // New start accepted directly from DONE
        run_op(1'b0, 8'd10, 8'd8, 0, 2, 10, 2, "from_done");

        // Random operations against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            h0  = int'($urandom_range(0, 255));
            tgt = h0 + int'($urandom_range(0, 24)) - 12;
            if (tgt < 0)   tgt = 0;
            if (tgt > 255) tgt = 255;
            d = (tgt > h0) ? tgt - h0 : h0 - tgt;
            exp_done = 2 + d * STEP;
            run_op(1'b1, W'(h0), W'(tgt), (tgt > h0) ? d : 0, (tgt < h0) ? d : 0,
                   exp_done, d, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_fill_ctrl.md
Name: tank_fill_ctrl

Overview:
- Closed-loop level controller directly upstream of the tank level counter; drives that block's fill/consume inputs and reads back its height/error outputs.
- Accepts a target level, issues single-cycle fill or consume pulses until height equals target, then reports done.
- Faults on tank overflow/underflow error or on pulse-budget exhaustion.

Parameters:
WIDTH, 8, width of target, height and pulse_cnt
GAP, 2, idle cycles after each pulse before height is re-compared (min 1; covers counter update latency)
MAX_PULSES, 255, pulse budget per operation before timeout fault
HYST, 4, refill hysteresis band (used only with TANK_AUTO_REFILL_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request new operation; accepted only in IDLE or DONE
target  in  WIDTH  desired level; latched on accepted start
height  in  WIDTH  current level from tank counter
tank_error  in  1  overflow/underflow flag from tank counter
abort  in  1  cancel current operation
fill  out  1  one-cycle fill pulse to tank
consume  out  1  one-cycle consume pulse to tank
busy  out  1  high in EVAL/PULSE/WAIT
done  out  1  high while in DONE
fault  out  1  high while in FAULT
fault_code  out  2  01 tank_error, 10 timeout, 00 none
pulse_cnt  out  WIDTH  pulses issued in current operation

Behaviour:
- Reset (async): state IDLE; fill, consume, busy, done, fault = 0; fault_code = 00; pulse_cnt = 0; latched target = 0; gap counter = 0.
- All outputs are registered or decoded from registered state; no combinational input-to-output path.
- Priority per cycle: rst > abort > tank_error > state logic.
- IDLE: start -> latch target, clear pulse_cnt and fault_code, go EVAL.
- EVAL (1 cycle): height == target -> DONE. Else if pulse_cnt == MAX_PULSES -> FAULT, code 10. Else height < target -> PULSE(dir=fill); height > target -> PULSE(dir=consume).
- PULSE (1 cycle): fill = 1 if dir=fill, else consume = 1; never both. pulse_cnt increments, saturating at all-ones. Load gap counter with GAP, go WAIT.
- WAIT: decrement gap counter; at zero go EVAL. A step therefore takes 2+GAP cycles.
- Direction is re-evaluated every EVAL; external height disturbances reverse direction without fault.
- DONE: done = 1; start -> latch new target, clear pulse_cnt, go EVAL next cycle; done drops the same cycle.
- start is ignored while busy; target changes while busy are ignored.
- abort in IDLE/EVAL/PULSE/WAIT/DONE -> IDLE next cycle. No pulse is issued in the cycle after abort is sampled. Ignored in FAULT.
- tank_error sampled high in EVAL/PULSE/WAIT/DONE -> FAULT, code 01. A pulse already registered in PULSE completes its single cycle.
- FAULT: fill = consume = 0, fault = 1, fault_code held. Exit only via rst; start and abort are ignored.
- Comparisons are unsigned WIDTH-bit.

Optional Feature:
- Macro: TANK_AUTO_REFILL_EN.
- Defined: in DONE, if height + HYST < target (computed at WIDTH+1 bits, no wrap), go EVAL automatically. done drops and pulse_cnt clears; operation proceeds as a normal fill.
- Undefined: DONE holds regardless of height drift; HYST is unused.

Test Plan:
- Reset with height=0; assert start with target=3 (GAP=2). Required: fill pulses on cycles 2, 6 and 10 after the start edge, with the tank model updating height. done rises at cycle 14, pulse_cnt=3, consume never high.
- height=5, target=2. Required: exactly 3 consume pulses spaced 4 cycles apart, then done; fill never high.
- target equals height at start. Required: done at cycle 2, pulse_cnt=0, no pulses.
- tank_error forced high during WAIT. Required: fault=1, fault_code=01 next cycle, no further pulses. start is ignored; only rst clears.
- MAX_PULSES=2, target=5 from height 0. Required: 2 fill pulses, then FAULT with fault_code=10 on the following EVAL.
- abort asserted during WAIT of a 4-pulse fill. Required: IDLE next cycle, busy=0, no further pulses. A subsequent start is accepted normally. With TANK_AUTO_REFILL_EN defined and HYST=4: after done at height 10, force height to 5; refill pulses resume and done returns at height 10. Forcing height to 6 instead must stay in DONE.
